// File: rtl/seg_readback_if.sv
// Segment-bus monitor interface: observed display bus in, reconstructed frame out.
interface seg_readback_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] value_out;
  logic                value_valid;
  logic                err;

  modport master (
    output seg_in,
    output dig_sel,
    input  value_out,
    input  value_valid,
    input  err
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    output value_out,
    output value_valid,
    output err
  );
endinterface

// File: rtl/seg_readback.sv
// Decodes a multiplexed active-low 7-segment bus back to a BCD frame for display self-check.
// Define SEG_READBACK_ERR_EN to flag undecodable patterns (nibble 4'hE and frame err bit).
module seg_readback #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  seg_readback_if.slave bus
);

  typedef enum logic [0:0] {StScan, StCommit} state_e;

  localparam logic [3:0]        StabTgt  = 4'(STABLE_CYCLES);
  localparam logic [DIGITS-1:0] MaskFull = {DIGITS{1'b1}};
`ifdef SEG_READBACK_ERR_EN
  localparam logic [3:0]        BadNib   = 4'hE;
`else
  localparam logic [3:0]        BadNib   = 4'hF;
`endif

  logic [DIGITS-1:0]      sel_q, sel_d;
  logic [6:0]             seg_q, seg_d;
  logic [3:0]             stab_q, stab_d;
  logic [DIGITS-1:0][3:0] slots_q, slots_d;
  logic [DIGITS-1:0]      mask_q, mask_d;
  state_e                 state_q, state_d;
  logic [4*DIGITS-1:0]    value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   pair_chg;
  logic                   cap;
  logic [3:0]             cap_nib;
`ifdef SEG_READBACK_ERR_EN
  logic                   ferr_q, ferr_d;
  logic                   err_q, err_d;
`endif

  function automatic logic [3:0] decode(input logic [6:0] seg_al);
    logic [6:0] p;
    p = ~seg_al;
    case (p)
      7'h3F:   decode = 4'd0;
      7'h06:   decode = 4'd1;
      7'h5B:   decode = 4'd2;
      7'h4F:   decode = 4'd3;
      7'h66:   decode = 4'd4;
      7'h6D:   decode = 4'd5;
      7'h7D:   decode = 4'd6;
      7'h07:   decode = 4'd7;
      7'h7F:   decode = 4'd8;
      7'h6F:   decode = 4'd9;
      7'h00:   decode = 4'hF;
      default: decode = BadNib;
    endcase
  endfunction

  // stab_q counts how many cycles the registered pair has held, so it is computed from the
  // pair about to be registered; this lands the capture edge at N+STABLE_CYCLES-1.
  always_comb begin
    sel_d    = bus.dig_sel;
    seg_d    = bus.seg_in;
    pair_chg = (sel_d != sel_q) || (seg_d != seg_q);

    if (!$onehot(sel_d)) begin
      stab_d = 4'd0;
    end else if (pair_chg) begin
      stab_d = 4'd1;
    end else if (stab_q < StabTgt) begin
      stab_d = stab_q + 4'd1;
    end else begin
      stab_d = stab_q;
    end

    // stab_d is non-zero only for a one-hot strobe, so this also qualifies the strobe.
    cap     = (stab_d == StabTgt) && ((stab_d != stab_q) || pair_chg);
    cap_nib = decode(seg_d);

    slots_d = slots_q;
    mask_d  = mask_q;
    state_d = state_q;
    value_d = value_q;
    valid_d = 1'b0;
`ifdef SEG_READBACK_ERR_EN
    ferr_d  = ferr_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      StScan: begin
        if (mask_q == MaskFull) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        value_d = slots_q;
        valid_d = 1'b1;
        mask_d  = '0;
        state_d = StScan;
`ifdef SEG_READBACK_ERR_EN
        err_d   = ferr_q;
        ferr_d  = 1'b0;
`endif
      end
      default: state_d = StScan;
    endcase

    // Applied after the commit clear so a capture during commit counts toward the next frame.
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cap && sel_d[i]) begin
        slots_d[i] = cap_nib;
        mask_d[i]  = 1'b1;
      end
    end
`ifdef SEG_READBACK_ERR_EN
    if (cap && (cap_nib == 4'hE)) begin
      ferr_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      seg_q   <= '0;
      stab_q  <= 4'd0;
      slots_q <= '0;
      mask_q  <= '0;
      state_q <= StScan;
      value_q <= '0;
      valid_q <= 1'b0;
`ifdef SEG_READBACK_ERR_EN
      ferr_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      stab_q  <= stab_d;
      slots_q <= slots_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      value_q <= value_d;
      valid_q <= valid_d;
`ifdef SEG_READBACK_ERR_EN
      ferr_q  <= ferr_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.value_out   = value_q;
  assign bus.value_valid = valid_q;
`ifdef SEG_READBACK_ERR_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_seg_readback.sv
// Directed self-checking bench for seg_readback (DIGITS=4, STABLE_CYCLES=3).
module tb_seg_readback;

  localparam int unsigned Digits = 4;

  // Active-low segment patterns.
  localparam logic [6:0] Seg0   = 7'h40;
  localparam logic [6:0] Seg1   = 7'h79;
  localparam logic [6:0] Seg2   = 7'h24;
  localparam logic [6:0] Seg3   = 7'h30;
  localparam logic [6:0] Seg4   = 7'h19;
  localparam logic [6:0] Seg5   = 7'h12;
  localparam logic [6:0] Seg7   = 7'h78;
  localparam logic [6:0] Seg8   = 7'h00;
  localparam logic [6:0] Seg9   = 7'h10;
  localparam logic [6:0] SegBlk = 7'h7F;
  localparam logic [6:0] SegBad = 7'b1110000;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  int   vv_cnt;
  int   vv_base;

  seg_readback_if #(.DIGITS(Digits)) bus_if ();

  seg_readback #(
    .DIGITS        (Digits),
    .STABLE_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.value_valid === 1'b1) vv_cnt <= vv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a pair just after an edge and hold it for n edges; returns #1 after the last edge.
  task automatic apply(input logic [3:0] sel, input logic [6:0] seg, input int n);
    bus_if.dig_sel = sel;
    bus_if.seg_in  = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    vv_cnt = 0;
    rst    = 1'b1;
    bus_if.dig_sel = 4'b0000;
    bus_if.seg_in  = SegBlk;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(bus_if.value_out), 32'h0);
    chk("rst_valid", 32'(bus_if.value_valid), 32'h0);
    chk("rst_err", 32'(bus_if.err), 32'h0);
    rst = 1'b0;
    apply(4'b0000, SegBlk, 2);

    // Frame "1234" shown digit 0..3, 4 cycles each; commit lands 5 edges after the last pair.
    apply(4'b0001, Seg1, 4);
    apply(4'b0010, Seg2, 4);
    apply(4'b0100, Seg3, 4);
    apply(4'b1000, Seg4, 4);
    apply(4'b0000, SegBlk, 1);
    chk("f1_valid_hi", 32'(bus_if.value_valid), 32'h1);
    apply(4'b0000, SegBlk, 1);
    chk("f1_valid_lo", 32'(bus_if.value_valid), 32'h0);
    apply(4'b0000, SegBlk, 4);
    chk("f1_value", 32'(bus_if.value_out), 32'h4321);
    chk("f1_err", 32'(bus_if.err), 32'h0);
    chk("f1_count", 32'(vv_cnt), 32'd1);

    // Each pair held only 2 cycles: never stable enough.
    for (int r = 0; r < 2; r++) begin
      apply(4'b0001, Seg5, 2);
      apply(4'b0010, Seg9, 2);
      apply(4'b0100, Seg7, 2);
      apply(4'b1000, Seg0, 2);
    end
    apply(4'b0000, SegBlk, 6);
    chk("glitch_count", 32'(vv_cnt), 32'd1);
    chk("glitch_hold", 32'(bus_if.value_out), 32'h4321);

    // Non-one-hot strobes.
    apply(4'b0000, Seg5, 10);
    chk("sel0_stab", 32'(dut.stab_q), 32'h0);
    apply(4'b0011, Seg5, 10);
    chk("sel3_stab", 32'(dut.stab_q), 32'h0);
    chk("badsel_count", 32'(vv_cnt), 32'd1);

    // Slot 1 undecodable, slot 2 all segments on.
    apply(4'b0001, Seg0, 4);
    apply(4'b0010, SegBad, 4);
    apply(4'b0100, Seg8, 4);
    apply(4'b1000, Seg3, 4);
    apply(4'b0000, SegBlk, 6);
    chk("bad_count", 32'(vv_cnt), 32'd2);
`ifdef SEG_READBACK_ERR_EN
    chk("bad_value", 32'(bus_if.value_out), 32'h38E0);
    chk("bad_err", 32'(bus_if.err), 32'h1);
`else
    chk("bad_value", 32'(bus_if.value_out), 32'h38F0);
    chk("bad_err", 32'(bus_if.err), 32'h0);
`endif

    // All blank; also shows the error bit does not carry into the next frame.
    apply(4'b0001, SegBlk, 4);
    apply(4'b0010, SegBlk, 4);
    apply(4'b0100, SegBlk, 4);
    apply(4'b1000, SegBlk, 4);
    apply(4'b0000, SegBlk, 6);
    chk("blank_count", 32'(vv_cnt), 32'd3);
    chk("blank_value", 32'(bus_if.value_out), 32'hFFFF);
    chk("blank_err", 32'(bus_if.err), 32'h0);

    // Partial frame discarded by reset; new frame shown slot 3 first, exactly 3 cycles each.
    apply(4'b0001, Seg1, 4);
    apply(4'b0010, Seg1, 4);
    apply(4'b0100, Seg1, 4);
    rst = 1'b1;
    apply(4'b0000, SegBlk, 1);
    rst = 1'b0;
    chk("rst2_value", 32'(bus_if.value_out), 32'h0);
    vv_base = vv_cnt;
    apply(4'b1000, Seg7, 3);
    apply(4'b0100, Seg5, 3);
    apply(4'b0010, Seg0, 3);
    apply(4'b0001, Seg9, 3);
    apply(4'b0000, SegBlk, 6);
    chk("rst2_count", 32'(vv_cnt - vv_base), 32'd1);
    chk("rst2_value_new", 32'(bus_if.value_out), 32'h7509);
    chk("rst2_err", 32'(bus_if.err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg_readback.md
# seg_readback

Inverse of the clock's BCD-to-7-segment encoder. Monitors the multiplexed, active-low segment bus plus the one-hot digit strobes driving the display, qualifies each digit's pattern for stability, decodes it back to BCD and assembles a full multi-digit frame. It is the self-check path for the clock display: the frame can be compared against the counter value that produced it.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, 1..8.
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a digit is captured, 1..15.

- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `seg_in` input 7: segment bus, active-low, bit 0 = segment a … bit 6 = segment g.
- `dig_sel` input DIGITS: digit strobe, active-high. Bit i set means `seg_in` currently shows digit i.
- `value_out` output 4*DIGITS: last committed frame. Digit i is in bits [4i+3:4i].
- `value_valid` output 1: one-cycle pulse when `value_out` updates.
- `err` output 1: the committed frame contained at least one undecodable pattern.

## Operation
- Input stage: `seg_in` and `dig_sel` are registered once before any other logic. All later logic uses the registered pair (`sel_r`, `seg_r`).
- Stability counter `stab`, 4 bits, saturating:
  - Reloads to 1 when (`sel_r`, `seg_r`) differs from the previous cycle's pair.
  - Otherwise increments, stopping at STABLE_CYCLES.
- Invalid strobe: if `sel_r` is not one-hot (zero or multiple bits set), `stab` is forced to 0 and nothing is captured.
- Capture: on the cycle `stab` increments to exactly STABLE_CYCLES with `sel_r` one-hot:
  - The decoded nibble is written to slot index(`sel_r`).
  - The slot's bit in the captured mask is set.
  - Each stable run captures once. A later run for the same slot in the same frame overwrites the slot.
- Decode, with the pattern inverted to active-high:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - All-off (`seg_r` = 7'h7F) → 4'hF, a legal blank.
  - Any other pattern → 4'hE, and the frame's error bit is set (see Configuration).
- State machine, two states:
  - SCAN: collect captures. When the mask becomes all-ones, go to COMMIT.
  - COMMIT, exactly one cycle:
    - `value_out` ← slots.
    - `value_valid` ← 1.
    - `err` ← frame error bit.
    - Clear the mask and the frame error bit, then return to SCAN.
  - A capture that arrives while in COMMIT is held in the slot and counts toward the next frame (its mask bit is set after the clear).

## Timing
- Reset values:
  - `value_out` = 0, `value_valid` = 0, `err` = 0.
  - Mask = 0, `stab` = 0, state = SCAN, input registers = 0.
- A pair first presented before edge N appears in `sel_r`/`seg_r` after edge N. The slot is written at edge N+STABLE_CYCLES−1.
- If that capture completes the frame: state = COMMIT after the next edge, and `value_out`/`value_valid`/`err` update one edge later (N+STABLE_CYCLES+1).
- `value_valid` is high for exactly one cycle per frame. `value_out` and `err` hold between commits.
- `rst` asserted mid-frame discards partial captures. No `value_valid` is produced for that frame.

## Configuration
- `SEG_READBACK_ERR_EN` defined:
  - Invalid patterns decode to 4'hE and set the frame error bit.
  - `err` reflects the frame error bit at each commit.
- `SEG_READBACK_ERR_EN` undefined:
  - Invalid patterns decode to 4'hF, identical to blank.
  - The error logic is removed and `err` is tied to 0.

## Test plan
- DIGITS=4, STABLE_CYCLES=3. Scan digits 0..3 showing "1","2","3","4", each held 4 cycles → one `value_valid` pulse, `value_out` = 16'h4321, `err` = 0.
- Glitchy digit: each pair held only 2 cycles → no capture, `value_valid` never asserts.
- `dig_sel` = 4'b0000 or 4'b0011 for 10 cycles → no capture, `stab` = 0.
- Slot 2 shows 7'b0000000 (all segments on, active-high 0x7F = "8") and slot 1 shows active-low 7'b1110000 (undefined pattern):
  - With the macro: `value_out` nibble 1 = 4'hE, `err` = 1.
  - Without the macro: nibble 1 = 4'hF, `err` = 0.
- Blank pattern 7'h7F on all digits → `value_out` = 16'hFFFF, `err` = 0.
- Three slots captured, then `rst` for 1 cycle, then a full new frame "9","0","5","7" → exactly one `value_valid`, `value_out` = 16'h7509.
